// File: rtl/instruction_fetch_pkg.sv
//==============================================================================
// Module   : instruction_fetch_pkg
// Brief    : Shared constants and IF/ID entry type for the instruction fetch stage
// Revision : 1.0
//==============================================================================
`default_nettype none

package instruction_fetch_pkg;

    localparam logic [31:0] c_DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_DEFAULT_NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] c_PC_STEP          = 32'd4;
    localparam logic [31:0] c_WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

    localparam logic [0:0] c_STATE_FETCH = 1'b0;
    localparam logic [0:0] c_STATE_HOLD  = 1'b1;

    typedef struct packed {
        logic [31:0] pcPlus4;
        logic [31:0] word;
    } ifid_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_hold_buffer.sv
//==============================================================================
// Module   : fetch_hold_buffer
// Brief    : One-entry store for a word that completed while the pipeline stalled
// Revision : 1.0
//==============================================================================
`default_nettype none

module fetch_hold_buffer
    import instruction_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_clear,
    input  ifid_entry_t i_entry,
    output logic        o_valid,
    output ifid_entry_t o_entry
);

    logic        r_valid;
    ifid_entry_t r_entry;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_entry <= i_entry;
        end
    end

    assign o_valid = r_valid;
    assign o_entry = r_entry;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
//==============================================================================
// Module   : instruction_fetch
// Brief    : IF stage: PC, variable-latency imem fetch, IF/ID register, stall/redirect
// Revision : 1.0
//==============================================================================
`default_nettype none

module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_WORD = c_DEFAULT_NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcWrite,
    input  logic        ifIdWrite,
    input  logic        branch,
    input  logic [31:0] branchProgramCounter,
    output logic        imemRequest,
    output logic [31:0] imemAddress,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] programCounterOut,
    output logic [31:0] instruction
);

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_imemAddress;
    logic        r_imemRequest;
    logic        r_squash;
    ifid_entry_t r_ifId;

    logic        w_done;
    logic        w_advance;
    logic        w_holdValid;
    logic        w_holdLoad;
    logic        w_holdClear;
    logic [31:0] w_branchTarget;
    logic [31:0] w_pcNext;
    ifid_entry_t w_fetched;
    ifid_entry_t w_bubble;
    ifid_entry_t w_held;

    always_comb begin
        w_done            = r_imemRequest & imemReady;
        w_advance         = pcWrite & ifIdWrite;
        w_branchTarget    = branchProgramCounter & c_WORD_ALIGN_MASK;
        w_pcNext          = r_pc + c_PC_STEP;
        w_fetched.pcPlus4 = r_imemAddress + c_PC_STEP;
        w_fetched.word    = imemData;
        w_bubble.pcPlus4  = r_ifId.pcPlus4;
        w_bubble.word     = NOP_WORD;
        w_holdLoad        = !branch && (r_state == c_STATE_FETCH) && w_done
                            && !r_squash && !w_advance;
        w_holdClear       = (r_state == c_STATE_HOLD)
                            && (branch || (w_advance && w_holdValid));
    end

    fetch_hold_buffer u_holdBuffer (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_holdLoad),
        .i_clear (w_holdClear),
        .i_entry (w_fetched),
        .o_valid (w_holdValid),
        .o_entry (w_held)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_STATE_FETCH;
            r_pc           <= RESET_PC;
            r_imemAddress  <= RESET_PC;
            r_imemRequest  <= 1'b0;
            r_squash       <= 1'b0;
            r_ifId.pcPlus4 <= 32'h0;
            r_ifId.word    <= NOP_WORD;
        end else if (branch) begin
            r_pc    <= w_branchTarget;
            r_state <= c_STATE_FETCH;
            if (r_state == c_STATE_HOLD) begin
                r_imemAddress <= w_branchTarget;
                r_imemRequest <= 1'b1;
            end else if (w_done) begin
                // The completing word still enters IF/ID; ID's flush discards it.
                if (!r_squash) begin
                    r_ifId <= w_fetched;
                end else if (ifIdWrite) begin
                    r_ifId <= w_bubble;
                end
                r_imemAddress <= w_branchTarget;
                r_imemRequest <= 1'b1;
                r_squash      <= 1'b0;
            end else if (r_imemRequest) begin
                // Outstanding request cannot be withdrawn; drop its word later.
                r_squash <= 1'b1;
                if (ifIdWrite) begin
                    r_ifId <= w_bubble;
                end
            end else begin
                r_imemAddress <= w_branchTarget;
                r_imemRequest <= 1'b1;
                if (ifIdWrite) begin
                    r_ifId <= w_bubble;
                end
            end
        end else if (r_state == c_STATE_FETCH) begin
            r_imemRequest <= 1'b1;
            if (w_done && r_squash) begin
                r_squash      <= 1'b0;
                r_imemAddress <= r_pc;
                if (ifIdWrite) begin
                    r_ifId <= w_bubble;
                end
            end else if (w_done && w_advance) begin
                r_ifId        <= w_fetched;
                r_pc          <= w_pcNext;
                r_imemAddress <= w_pcNext;
            end else if (w_done) begin
                r_imemRequest <= 1'b0;
                r_state       <= c_STATE_HOLD;
            end else if (ifIdWrite) begin
                r_ifId <= w_bubble;
            end
        end else if (w_advance && w_holdValid) begin
            r_ifId        <= w_held;
            r_pc          <= w_pcNext;
            r_imemAddress <= w_pcNext;
            r_imemRequest <= 1'b1;
            r_state       <= c_STATE_FETCH;
        end
    end

    assign imemRequest       = r_imemRequest;
    assign imemAddress       = r_imemAddress;
    assign programCounterOut = r_ifId.pcPlus4;
    assign instruction       = r_ifId.word;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
//==============================================================================
// Module   : tb_instruction_fetch
// Brief    : Directed self-checking bench for instruction_fetch
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_instruction_fetch;

    localparam logic [31:0] c_NOP  = 32'h0000_0013;
    localparam logic [31:0] c_WRAP = 32'hFFFF_FFFC;

    logic        clk;
    logic        reset;
    logic        pcWrite;
    logic        ifIdWrite;
    logic        branch;
    logic [31:0] branchProgramCounter;
    logic        imemReady;

    logic        imemRequest,  imemRequest2;
    logic [31:0] imemAddress,  imemAddress2;
    logic [31:0] imemData,     imemData2;
    logic [31:0] programCounterOut, programCounterOut2;
    logic [31:0] instruction,  instruction2;

    int vectors     = 0;
    int miscompares = 0;

    // Memory model: each word holds its own word index.
    assign imemData  = imemAddress  >> 2;
    assign imemData2 = imemAddress2 >> 2;

    instruction_fetch #(.RESET_PC(32'h0), .NOP_WORD(c_NOP)) dut (
        .clk                  (clk),
        .reset                (reset),
        .pcWrite              (pcWrite),
        .ifIdWrite            (ifIdWrite),
        .branch               (branch),
        .branchProgramCounter (branchProgramCounter),
        .imemRequest          (imemRequest),
        .imemAddress          (imemAddress),
        .imemReady            (imemReady),
        .imemData             (imemData),
        .programCounterOut    (programCounterOut),
        .instruction          (instruction)
    );

    instruction_fetch #(.RESET_PC(c_WRAP), .NOP_WORD(c_NOP)) dutWrap (
        .clk                  (clk),
        .reset                (reset),
        .pcWrite              (pcWrite),
        .ifIdWrite            (ifIdWrite),
        .branch               (branch),
        .branchProgramCounter (branchProgramCounter),
        .imemRequest          (imemRequest2),
        .imemAddress          (imemAddress2),
        .imemReady            (1'b1),
        .imemData             (imemData2),
        .programCounterOut    (programCounterOut2),
        .instruction          (instruction2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT one edge past release: request up at RESET_PC.
    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; pcWrite = 1'b1; ifIdWrite = 1'b1; branch = 1'b0;
        branchProgramCounter = 32'h0; imemReady = 1'b1;

        // 1. reset state, then back-to-back fetch
        tick(); tick(); tick();
        check("rst_req",   {31'h0, imemRequest}, 32'h0);
        check("rst_addr",  imemAddress, 32'h0);
        check("rst_instr", instruction, c_NOP);
        check("rst_pcout", programCounterOut, 32'h0);
        check("wrap_rst_addr", imemAddress2, c_WRAP);
        reset = 1'b0;
        tick();
        check("t1_req",   {31'h0, imemRequest}, 32'h1);
        check("t1_addr0", imemAddress, 32'h0);
        check("wrap_addr0", imemAddress2, c_WRAP);
        tick();
        check("t1_addr4",  imemAddress, 32'h4);
        check("t1_instr0", instruction, 32'h0);
        check("t1_pc4",    programCounterOut, 32'h4);
        check("wrap_addr1", imemAddress2, 32'h0);
        check("wrap_pcout", programCounterOut2, 32'h0);
        check("wrap_instr", instruction2, 32'h3FFF_FFFF);
        tick();
        check("t1_addr8",  imemAddress, 32'h8);
        check("t1_instr1", instruction, 32'h1);
        check("t1_pc8",    programCounterOut, 32'h8);
        tick();
        check("t1_addr12", imemAddress, 32'hC);
        check("t1_instr2", instruction, 32'h2);
        check("t1_pc12",   programCounterOut, 32'hC);

        // 2. memory wait states produce bubbles
        doReset();
        tick(); tick();
        check("t2_addr8", imemAddress, 32'h8);
        imemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_bubble_instr", instruction, c_NOP);
            check("t2_bubble_pc",    programCounterOut, 32'h8);
            check("t2_addr_stable",  imemAddress, 32'h8);
        end
        imemReady = 1'b1;
        tick();
        check("t2_instr2", instruction, 32'h2);
        check("t2_pc12",   programCounterOut, 32'hC);

        // 3. stall while the word at 4 completes
        doReset();
        tick();
        check("t3_addr4", imemAddress, 32'h4);
        pcWrite = 1'b0; ifIdWrite = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t3_hold_req",   {31'h0, imemRequest}, 32'h0);
            check("t3_hold_instr", instruction, 32'h0);
            check("t3_hold_pc",    programCounterOut, 32'h4);
        end
        pcWrite = 1'b1; ifIdWrite = 1'b1;
        tick();
        check("t3_rel_instr", instruction, 32'h1);
        check("t3_rel_pc",    programCounterOut, 32'h8);
        check("t3_rel_req",   {31'h0, imemRequest}, 32'h1);
        check("t3_rel_addr",  imemAddress, 32'h8);

        // 4. branch while request to 0x10 is pending
        doReset();
        tick(); tick(); tick(); tick();
        check("t4_addr10", imemAddress, 32'h10);
        imemReady = 1'b0; branch = 1'b1; branchProgramCounter = 32'h100;
        tick();
        branch = 1'b0;
        check("t4_addr_kept", imemAddress, 32'h10);
        check("t4_req_kept",  {31'h0, imemRequest}, 32'h1);
        tick();
        imemReady = 1'b1;
        tick();
        check("t4_dropped",  instruction, c_NOP);
        check("t4_redirect", imemAddress, 32'h100);
        tick();
        check("t4_tgt_instr", instruction, 32'h40);
        check("t4_tgt_pc",    programCounterOut, 32'h104);

        // 5. branch coincident with completion at 0x14
        doReset();
        tick(); tick(); tick(); tick(); tick();
        check("t5_addr14", imemAddress, 32'h14);
        branch = 1'b1; branchProgramCounter = 32'h40;
        tick();
        branch = 1'b0;
        check("t5_instr5", instruction, 32'h5);
        check("t5_pc18",   programCounterOut, 32'h18);
        check("t5_addr40", imemAddress, 32'h40);
        tick();
        check("t5_tgt_instr", instruction, 32'h10);

        // 6. reset mid-transfer
        doReset();
        tick();
        imemReady = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("t6_req",   {31'h0, imemRequest}, 32'h0);
        check("t6_instr", instruction, c_NOP);
        check("t6_addr",  imemAddress, 32'h0);
        check("t6_pcout", programCounterOut, 32'h0);
        reset = 1'b0;
        imemReady = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
